frame_swap_controller: RTL
==========================

# frame_swap_controller

Double-buffer sequencer for the pixel memory feeding the 8-channel LED output path. It owns the bank-select bit that the read arbiter and LED channel drivers see, and the host writer uses the inverse bank. On each refresh tick it drains the channel drivers, swaps banks if the host has committed a new frame, then launches all enabled channels together.

## Interface
Parameters:
- NUM_CHANNELS, 8, number of LED output channels.
- DRAIN_TIMEOUT, 1024, maximum number of cycles spent in DRAIN before the frame is abandoned (1..65535).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle refresh-period pulse.
- host_commit  in  1  one-cycle pulse: host has finished writing the back bank.
- chan_enable  in  NUM_CHANNELS  mask of active channels.
- chan_busy  in  NUM_CHANNELS  per-channel "still shifting out" flags.
- front_bank  out  1  bank read by the arbiter and channels.
- back_bank  out  1  always ~front_bank; bank written by the host.
- chan_start  out  NUM_CHANNELS  start strobe per channel.
- commit_ack  out  1  pulse: the committed frame has been swapped to front.
- commit_pending  out  1  a commit is latched and not yet swapped.
- frame_overrun  out  1  pulse: a frame was skipped or abandoned.
- overrun_count  out  8  saturating count of frame_overrun pulses.
- frame_count  out  16  wrapping count of launches.

## Operation
- States: IDLE, DRAIN, SWAP, LAUNCH. State register is 2 bits; reset puts it in IDLE.
- IDLE: on frame_tick, go to DRAIN and clear drain_cnt.
- DRAIN: let busy_any = |(chan_busy & chan_enable).
  - If busy_any = 0: go to SWAP when commit_pending = 1, otherwise go to LAUNCH.
  - Else if drain_cnt = DRAIN_TIMEOUT-1: go to IDLE, pulse frame_overrun, and do not launch.
  - Else increment drain_cnt (16 bits).
- SWAP: commit_ack = 1 for this cycle. front_bank toggles on the exiting edge. commit_pending clears. Next state is LAUNCH.
- LAUNCH: chan_start = chan_enable, using the value sampled in this cycle. frame_count increments (wraps 0xFFFF→0). Next state is IDLE.
- commit_pending:
  - Set by host_commit in any state.
  - Cleared in SWAP. If host_commit arrives in the SWAP cycle itself, set wins and the new commit stays pending.
  - A second host_commit while already pending has no further effect; no queueing.
- frame_tick while not in IDLE is ignored for sequencing and pulses frame_overrun.
- overrun_count increments on every frame_overrun pulse and saturates at 0xFF.
- chan_enable = 0 is legal. DRAIN exits immediately and LAUNCH issues an all-zero chan_start, but frame_count still increments.
- Reset in any state:
  - state=IDLE, front_bank=0, back_bank=1.
  - chan_start=0, commit_ack=0, commit_pending=0, frame_overrun=0.
  - overrun_count=0, frame_count=0, drain_cnt=0.

## Timing
- commit_ack and chan_start are Moore outputs decoded from the state register: high only during the SWAP and LAUNCH cycles respectively, never longer than 1 cycle.
- frame_overrun is registered and lasts 1 cycle.
- Swap path: tick at cycle N (IDLE), N+1 DRAIN with busy_any=0, N+2 SWAP with commit_ack=1, N+3 LAUNCH with front_bank at its new value and chan_start=mask, N+4 IDLE.
- No-commit path: tick N, DRAIN N+1, LAUNCH N+2, IDLE N+3.
- front_bank never changes while any chan_start is high, or between LAUNCH and the next SWAP.
- Timeout: entering DRAIN at N with busy held high gives frame_overrun=1 at N+DRAIN_TIMEOUT, with state IDLE in that same cycle.
- host_commit and frame_tick in the same IDLE cycle: the commit is latched by N+1, so that same frame swaps.

## Test plan
- Reset, chan_enable=0xFF, busy=0, host_commit at cycle 5, frame_tick at cycle 10 → commit_ack at 12, front_bank 0→1 at 13, chan_start=0xFF at 13 only, frame_count=1.
- frame_tick with no commit → chan_start=0xFF 2 cycles later, front_bank stays 0, commit_ack never asserts.
- chan_busy=0x04 held for 20 cycles after tick, DRAIN_TIMEOUT=1024 → launch 1 cycle after busy drops. chan_enable=0xFB with busy=0x04 → immediate launch, no wait.
- DRAIN_TIMEOUT=16, busy stuck at 0x01 → frame_overrun pulse 16 cycles after DRAIN entry, no chan_start, overrun_count=1. Repeat 300 times → overrun_count saturates at 255.
- host_commit coincident with the SWAP cycle → commit_ack once, commit_pending=1 afterwards, and the next tick swaps again (front_bank back to 0).
- rst asserted during DRAIN and again during SWAP → all outputs at reset values on the next cycle, front_bank=0, and the pending commit is lost.

Source files
------------

// File: rtl/frame_swap_controller.sv
// Double-buffer sequencer for the LED pixel memory: drains the channel drivers on each
// refresh tick, swaps front/back banks when the host has committed a frame, then launches.
module frame_swap_controller #(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    host_commit,
  input  logic [NUM_CHANNELS-1:0] chan_enable,
  input  logic [NUM_CHANNELS-1:0] chan_busy,
  output logic                    front_bank,
  output logic                    back_bank,
  output logic [NUM_CHANNELS-1:0] chan_start,
  output logic                    commit_ack,
  output logic                    commit_pending,
  output logic                    frame_overrun,
  output logic [7:0]              overrun_count,
  output logic [15:0]             frame_count
);

  localparam int unsigned DRAIN_CNT_W = 16;
  localparam int unsigned OVR_CNT_W   = 8;
  localparam int unsigned FRM_CNT_W   = 16;

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWAP   = 2'd2,
    LAUNCH = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   front_bank_q, front_bank_d;
  logic                   commit_pending_q, commit_pending_d;
  logic                   frame_overrun_q, frame_overrun_d;
  logic [OVR_CNT_W-1:0]   overrun_count_q, overrun_count_d;
  logic [FRM_CNT_W-1:0]   frame_count_q, frame_count_d;

  logic busy_any;
  logic drain_timeout;
  logic tick_overrun;

  assign busy_any      = |(chan_busy & chan_enable);
  assign drain_timeout = (state_q == DRAIN) && busy_any && (drain_cnt_q == DRAIN_LAST);
  assign tick_overrun  = frame_tick && (state_q != IDLE);

  // State register and all sequential bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      drain_cnt_q      <= '0;
      front_bank_q     <= 1'b0;
      commit_pending_q <= 1'b0;
      frame_overrun_q  <= 1'b0;
      overrun_count_q  <= '0;
      frame_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      front_bank_q     <= front_bank_d;
      commit_pending_q <= commit_pending_d;
      frame_overrun_q  <= frame_overrun_d;
      overrun_count_q  <= overrun_count_d;
      frame_count_q    <= frame_count_d;
    end
  end

  // Sequencing: IDLE -> DRAIN -> (SWAP) -> LAUNCH -> IDLE, with drain timeout back to IDLE
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!busy_any) begin
          state_d = commit_pending_q ? SWAP : LAUNCH;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      SWAP:    state_d = LAUNCH;
      LAUNCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank flip, commit tracking and counters
  always_comb begin
    front_bank_d     = front_bank_q;
    commit_pending_d = commit_pending_q;
    frame_overrun_d  = drain_timeout || tick_overrun;
    overrun_count_d  = overrun_count_q;
    frame_count_d    = frame_count_q;

    if (state_q == SWAP) begin
      front_bank_d     = ~front_bank_q;
      commit_pending_d = 1'b0;
    end
    // A commit landing in the SWAP cycle belongs to the next frame, so set wins
    if (host_commit) begin
      commit_pending_d = 1'b1;
    end

    if (frame_overrun_d && (overrun_count_q != '1)) begin
      overrun_count_d = overrun_count_q + OVR_CNT_W'(1);
    end

    if (state_q == LAUNCH) begin
      frame_count_d = frame_count_q + FRM_CNT_W'(1);
    end
  end

  // Moore strobes decoded from the state register
  assign commit_ack     = (state_q == SWAP);
  assign chan_start     = (state_q == LAUNCH) ? chan_enable : '0;

  assign front_bank     = front_bank_q;
  assign back_bank      = ~front_bank_q;
  assign commit_pending = commit_pending_q;
  assign frame_overrun  = frame_overrun_q;
  assign overrun_count  = overrun_count_q;
  assign frame_count    = frame_count_q;

endmodule
